// File: rtl/dmem_sched_pkg.sv
// Shared types for the dmem scheduler: FSM state and conflict-winner tag.
package dmem_sched_pkg;
    typedef enum logic {S_RUN, S_HALTED} sched_st_t;
    typedef enum logic {W_CPU, W_HOST} win_t;
endpackage

// File: rtl/dmem_sched_sat_cnt.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module dmem_sched_sat_cnt #(
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            inc_i,
    output logic [CNTW-1:0] cnt_o
);
    logic [CNTW-1:0] cnt_q;

    // increment unless already at the ceiling
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                    cnt_q <= '0;
        else if (inc_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_sched.sv
// Single-port dmem scheduler: round-robin between core and host on conflict,
// host HALT mode freezes the core and gives the host exclusive access.
module dmem_sched
    import dmem_sched_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [AW-1:0]   cpu_addr_i,
    input  logic [DW-1:0]   cpu_wdata_i,
    output logic [DW-1:0]   cpu_rdata_o,
    output logic            cpu_stall_o,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [AW-1:0]   host_addr_i,
    input  logic [DW-1:0]   host_wdata_i,
    output logic [DW-1:0]   host_rdata_o,
    output logic            host_ack_o,
    input  logic            host_halt_i,
    output logic            halted_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_di_o,
    input  logic [DW-1:0]   mem_dout_i,
    output logic [CNTW-1:0] stall_cnt_o,
    output logic [CNTW-1:0] conflict_cnt_o
);
    sched_st_t       state_q, state_d;
    win_t            last_win_q, last_win_d;
    logic            host_pend_q;
    logic [DW-1:0]   host_rdata_q;
    logic            host_elig, gnt_cpu, gnt_host, conflict;

    // host may not re-access in its own ack cycle (max 1 access / 2 cycles)
    assign host_elig = host_req_i & ~host_pend_q;

    // state, winner history and host response registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_RUN;
            last_win_q   <= W_HOST;
            host_pend_q  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_win_q  <= last_win_d;
            host_pend_q <= gnt_host;
            if (gnt_host) host_rdata_q <= mem_dout_i;
        end
    end

    // next state and per-cycle grant; grants are suppressed while reset is
    // asserted so no store can land during reset
    always_comb begin
        state_d    = host_halt_i ? S_HALTED : S_RUN;
        last_win_d = last_win_q;
        gnt_cpu    = 1'b0;
        gnt_host   = 1'b0;
        conflict   = 1'b0;
        if (reset_ni) begin
            if (state_q == S_HALTED) begin
                gnt_host = host_elig;
            end else begin
                conflict = cpu_req_i & host_elig;
                if (conflict) begin
                    // history only advances on real conflicts
                    gnt_cpu    = (last_win_q == W_HOST);
                    gnt_host   = ~gnt_cpu;
                    last_win_d = gnt_cpu ? W_CPU : W_HOST;
                end else begin
                    gnt_cpu  = cpu_req_i;
                    gnt_host = host_elig;
                end
            end
        end
    end

    // memory port mux driven by the winner; idle bus is all-zero
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_di_o   = '0;
        if (gnt_cpu) begin
            mem_we_o   = cpu_we_i;
            mem_addr_o = cpu_addr_i;
            mem_di_o   = cpu_wdata_i;
        end else if (gnt_host) begin
            mem_we_o   = host_we_i;
            mem_addr_o = host_addr_i;
            mem_di_o   = host_wdata_i;
        end
    end

    assign halted_o     = (state_q == S_HALTED);
    assign cpu_stall_o  = halted_o | (cpu_req_i & ~gnt_cpu);
    assign cpu_rdata_o  = mem_dout_i;
    assign host_ack_o   = host_pend_q;
    assign host_rdata_o = host_rdata_q;

    dmem_sched_sat_cnt #(.CNTW(CNTW)) u_stall_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (cpu_stall_o),
        .cnt_o    (stall_cnt_o)
    );

    dmem_sched_sat_cnt #(.CNTW(CNTW)) u_conflict_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (conflict),
        .cnt_o    (conflict_cnt_o)
    );
endmodule

// File: tb/tb_dmem_sched.sv
// Directed bench for dmem_sched with a behavioural single-port dmem.
module tb_dmem_sched;
    localparam int AW = 8, DW = 8, CNTW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cpu_req, cpu_we, host_req, host_we, host_halt;
    logic [AW-1:0]   cpu_addr, host_addr;
    logic [DW-1:0]   cpu_wdata, host_wdata;
    logic [DW-1:0]   cpu_rdata, host_rdata, mem_di, mem_dout;
    logic            cpu_stall, host_ack, halted, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [CNTW-1:0] stall_cnt, conflict_cnt;

    logic [DW-1:0]   mem [256];
    int              n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // dmem: combinational read, write at rising edge
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_di;

    dmem_sched #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_rdata_o(host_rdata), .host_ack_o(host_ack),
        .host_halt_i(host_halt), .halted_o(halted),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_di_o(mem_di), .mem_dout_i(mem_dout),
        .stall_cnt_o(stall_cnt), .conflict_cnt_o(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge, then inputs may change
    task automatic step();
        @(posedge clk); #1;
    endtask

    // C,H,-,C,H,- expected grant pattern for the contention test
    logic       exp_stall [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_addr  [6] = '{8'h10, 8'h11, 8'h10, 8'h10, 8'h11, 8'h10};
    logic       exp_ack   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'h77;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_halt = 0;

        // reset state
        @(negedge clk);
        chk("rst_ack", host_ack, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_stallcnt", stall_cnt, 0);
        chk("rst_confcnt", conflict_cnt, 0);
        chk("rst_memwe", mem_we, 0);
        reset_n = 1'b1;

        // 1: lone core load, zero latency
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        chk("t1_stall", cpu_stall, 0);
        chk("t1_rdata", cpu_rdata, 8'h5A);

        // 2: both requesting for 6 cycles
        step();
        host_req = 1; host_we = 0; host_addr = 8'h11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("t2_stall%0d", c), cpu_stall, exp_stall[c]);
            chk($sformatf("t2_addr%0d", c), mem_addr, exp_addr[c]);
            chk($sformatf("t2_ack%0d", c), host_ack, exp_ack[c]);
            if (c == 5) chk("t2_hrdata", host_rdata, 8'h77);
            step();
        end
        cpu_req = 0; host_req = 0;
        @(negedge clk);
        chk("t2_confcnt", conflict_cnt, 4);
        chk("t2_stallcnt", stall_cnt, 2);

        // 3: host write then host read back
        step();
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h33;
        @(negedge clk);
        chk("t3_we", mem_we, 1);
        chk("t3_waddr", mem_addr, 8'h20);
        chk("t3_wdata", mem_di, 8'h33);
        step();
        host_we = 0;
        @(negedge clk);
        chk("t3_ack_w", host_ack, 1);
        chk("t3_pend_nowe", mem_we, 0);
        chk("t3_mem", mem[8'h20], 8'h33);
        step();
        @(negedge clk);
        chk("t3_ack_gap", host_ack, 0);
        chk("t3_raddr", mem_addr, 8'h20);
        step();
        host_req = 0;
        @(negedge clk);
        chk("t3_ack_r", host_ack, 1);
        chk("t3_rdata", host_rdata, 8'h33);

        // 4: halt with core continuously requesting
        step();
        cpu_req = 1; cpu_addr = 8'h10; host_halt = 1;
        @(negedge clk);
        chk("t4_sample_halted", halted, 0);
        chk("t4_sample_stall", cpu_stall, 0);
        chk("t4_sample_addr", mem_addr, 8'h10);
        step();
        host_req = 1; host_we = 0; host_addr = 8'h20;
        @(negedge clk);
        chk("t4_halted", halted, 1);
        chk("t4_stall", cpu_stall, 1);
        chk("t4_haddr", mem_addr, 8'h20);
        step();
        @(negedge clk);
        chk("t4_ack", host_ack, 1);
        chk("t4_hrdata", host_rdata, 8'h33);
        chk("t4_idle_addr", mem_addr, 8'h00);
        step();
        @(negedge clk);
        chk("t4_regrant", mem_addr, 8'h20);
        step();
        host_req = 0; host_halt = 0;
        @(negedge clk);
        chk("t4_still_halted", halted, 1);
        chk("t4_still_stall", cpu_stall, 1);
        step();
        @(negedge clk);
        chk("t4_run", halted, 0);
        chk("t4_run_stall", cpu_stall, 0);
        chk("t4_run_addr", mem_addr, 8'h10);

        // 6: stall counter saturation while halted
        step();
        host_halt = 1;
        for (int c = 0; c < 21; c++) step();
        @(negedge clk);
        chk("t6_halted", halted, 1);
        chk("t6_stall_sat", stall_cnt, 15);
        chk("t6_conf_hold", conflict_cnt, 4);

        // 5: reset in the grant cycle of a host write
        step();
        host_req = 1; host_we = 1; host_addr = 8'h30; host_wdata = 8'h99;
        @(negedge clk);
        chk("t5_grant_we", mem_we, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_ack", host_ack, 0);
        chk("t5_halted", halted, 0);
        chk("t5_stallcnt", stall_cnt, 0);
        chk("t5_confcnt", conflict_cnt, 0);
        chk("t5_memwe", mem_we, 0);
        chk("t5_rdata", host_rdata, 0);
        step();
        chk("t5_no_commit", mem[8'h30], 8'h00);
        host_req = 0; cpu_req = 0; host_halt = 0;
        reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
